// File: rtl/tri_diag_recip.sv
// rtl/tri_diag_recip.sv - diagonal reciprocal engine for the triangular-inversion path
// Issues 1/d per row through an external pipelined divider and buffers the quotients in row order.
module tri_diag_recip #(
  parameter int SIZE            = 16,
  parameter int FLEN            = 64,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic                    unit_diag_i,
  input  logic                    flush_i,
  output logic [$clog2(SIZE)-1:0] row_req_addr_o,
  output logic                    row_req_valid_o,
  input  logic [SIZE*2*FLEN-1:0]  row_rsp_i,
  input  logic [$clog2(SIZE)-1:0] row_rsp_addr_i,
  input  logic                    row_rsp_valid_i,
  output logic [4*FLEN-1:0]       div_operands_o,
  output logic                    div_in_valid_o,
  input  logic                    div_in_ready_i,
  input  logic [2*FLEN-1:0]       div_result_i,
  input  logic                    div_out_valid_i,
  output logic                    div_out_ready_o,
  output logic                    div_flush_o,
  input  logic [$clog2(SIZE)-1:0] recip_rd_addr_i,
  output logic [2*FLEN-1:0]       recip_rd_data_o,
  output logic                    done_o,
  output logic                    singular_o,
  output logic                    busy_o
);
  localparam int AW = $clog2(SIZE);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  // 1.0 in the IEEE binary format matching FLEN: biased exponent only, zero mantissa.
  localparam int EW = (FLEN == 16) ? 5 : (FLEN == 32) ? 8 : (FLEN == 128) ? 15 : 11;
  localparam logic [FLEN-1:0] BIAS = FLEN'((2 ** (EW - 1)) - 1);
  localparam logic [FLEN-1:0] ONE  = BIAS << (FLEN - 1 - EW);
  localparam logic [AW-1:0]   LAST = AW'(SIZE - 1);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                     state_q;
  logic [AW-1:0]              iss_ptr_q;
  logic [AW-1:0]              wr_ptr_q;
  logic [CW-1:0]              credit_q;
  logic [MAX_OUTSTANDING-1:0] tag_q;
  logic [MAX_OUTSTANDING-1:0] tag_d;
  logic                       singular_q;
  logic [2*FLEN-1:0]          recip_buf [SIZE];

  logic [2*FLEN-1:0] diag;
  logic [CW-1:0]     tag_slot;
  logic              diag_zero;
  logic              consume;
  logic              iss_fire;
  logic              ret_fire;

  assign diag      = row_rsp_i[int'(iss_ptr_q) * 2 * FLEN +: 2 * FLEN];
  assign diag_zero = ~|diag[FLEN-2:0] & ~|diag[2*FLEN-2:FLEN];

  // Credit is checked before any same-cycle return is applied.
  assign consume = (state_q == S_ISSUE) && row_rsp_valid_i &&
                   (row_rsp_addr_i == iss_ptr_q) && (credit_q < CW'(MAX_OUTSTANDING));

  assign div_in_valid_o  = consume;
  assign iss_fire        = consume & div_in_ready_i;
  assign div_out_ready_o = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign ret_fire        = div_out_valid_i & div_out_ready_o;
  assign div_flush_o     = flush_i;
  assign div_operands_o  = (state_q == S_ISSUE) ?
                           {diag[2*FLEN-1:FLEN], diag[FLEN-1:0], {FLEN{1'b0}}, ONE} : '0;

  assign row_req_valid_o = (state_q == S_ISSUE);
  assign row_req_addr_o  = iss_ptr_q;
  assign done_o          = (state_q == S_DONE);
  assign busy_o          = state_q inside {S_FILL, S_ISSUE, S_DRAIN};
  assign singular_o      = singular_q;
  assign recip_rd_data_o = recip_buf[recip_rd_addr_i];

  // Tag FIFO kept as a shift register: head at bit 0, occupancy equals credit.
  assign tag_slot = credit_q - CW'(ret_fire);
  always_comb begin
    tag_d = tag_q;
    if (ret_fire) tag_d = tag_q >> 1;
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (iss_fire && (tag_slot == CW'(i))) tag_d[i] = diag_zero;
    end
  end

  always_ff @(posedge clk_i) begin
    if (state_q == S_FILL) recip_buf[wr_ptr_q] <= {{FLEN{1'b0}}, ONE};
    else if (ret_fire)     recip_buf[wr_ptr_q] <= tag_q[0] ? '0 : div_result_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      iss_ptr_q  <= '0;
      wr_ptr_q   <= '0;
      credit_q   <= '0;
      tag_q      <= '0;
      singular_q <= 1'b0;
    end else if (flush_i) begin
      state_q    <= S_IDLE;
      iss_ptr_q  <= '0;
      wr_ptr_q   <= '0;
      credit_q   <= '0;
      tag_q      <= '0;
      singular_q <= 1'b0;
    end else begin
      tag_q <= tag_d;
      if (iss_fire) iss_ptr_q <= iss_ptr_q + 1'b1;
      if ((state_q == S_FILL) || ret_fire) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (ret_fire && tag_q[0]) singular_q <= 1'b1;
      if (iss_fire && !ret_fire) credit_q <= credit_q + 1'b1;
      else if (ret_fire && !iss_fire && (credit_q != '0)) credit_q <= credit_q - 1'b1;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state_q    <= unit_diag_i ? S_FILL : S_ISSUE;
            iss_ptr_q  <= '0;
            wr_ptr_q   <= '0;
            credit_q   <= '0;
            tag_q      <= '0;
            singular_q <= 1'b0;
          end
        end
        S_FILL:  if (wr_ptr_q == LAST) state_q <= S_DONE;
        S_ISSUE: if (iss_fire && (iss_ptr_q == LAST)) state_q <= S_DRAIN;
        S_DRAIN: if (ret_fire && (wr_ptr_q == LAST)) state_q <= S_DONE;
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tri_diag_recip.sv
// tb/tb_tri_diag_recip.sv - self-checking bench for tri_diag_recip
// Reference model tracks issue/return counts per run; a latency-queue divider model answers requests.
module tb_tri_diag_recip;
  localparam int SIZE = 16;
  localparam int FLEN = 64;
  localparam int MO   = 4;
  localparam int AW   = $clog2(SIZE);
  localparam int M_IDLE = 0, M_UNIT = 1, M_DIV = 2;

  logic                   clk_i = 1'b0;
  logic                   rst_ni = 1'b1;
  logic                   start_i = 1'b0, unit_diag_i = 1'b0, flush_i = 1'b0;
  logic [AW-1:0]          row_req_addr_o;
  logic                   row_req_valid_o;
  logic [SIZE*2*FLEN-1:0] row_rsp_i = '0;
  logic [AW-1:0]          row_rsp_addr_i = '0;
  logic                   row_rsp_valid_i = 1'b0;
  logic [4*FLEN-1:0]      div_operands_o;
  logic                   div_in_valid_o;
  logic                   div_in_ready_i = 1'b0;
  logic [2*FLEN-1:0]      div_result_i = '0;
  logic                   div_out_valid_i = 1'b0;
  logic                   div_out_ready_o, div_flush_o;
  logic [AW-1:0]          recip_rd_addr_i = '0;
  logic [2*FLEN-1:0]      recip_rd_data_o;
  logic                   done_o, singular_o, busy_o;

  always #5 clk_i = ~clk_i;

  tri_diag_recip #(.SIZE(SIZE), .FLEN(FLEN), .MAX_OUTSTANDING(MO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .unit_diag_i(unit_diag_i), .flush_i(flush_i),
    .row_req_addr_o(row_req_addr_o), .row_req_valid_o(row_req_valid_o),
    .row_rsp_i(row_rsp_i), .row_rsp_addr_i(row_rsp_addr_i), .row_rsp_valid_i(row_rsp_valid_i),
    .div_operands_o(div_operands_o), .div_in_valid_o(div_in_valid_o), .div_in_ready_i(div_in_ready_i),
    .div_result_i(div_result_i), .div_out_valid_i(div_out_valid_i), .div_out_ready_o(div_out_ready_o),
    .div_flush_o(div_flush_o), .recip_rd_addr_i(recip_rd_addr_i), .recip_rd_data_o(recip_rd_data_o),
    .done_o(done_o), .singular_o(singular_o), .busy_o(busy_o)
  );

  int n_chk = 0, n_pass = 0;
  int cyc = 0, start_cyc = 0;
  logic [2*FLEN-1:0] diag [SIZE];
  int m_mode, m_iss, m_ret, m_fill;
  bit m_done, m_sing, last_unit;
  int lat;
  bit rnd_ready, rnd_rows;
  logic [2*FLEN-1:0] pq_data [$];
  int pq_due [$];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [127:0] cdiv(input real a1, input real b1, input real a2, input real b2);
    real den;
    den = a2 * a2 + b2 * b2;
    return {$realtobits((b1 * a2 - a1 * b2) / den), $realtobits((a1 * a2 + b1 * b2) / den)};
  endfunction

  function automatic bit is_zero(input logic [127:0] z);
    return ($bitstoreal(z[63:0]) == 0.0) && ($bitstoreal(z[127:64]) == 0.0);
  endfunction

  function automatic logic [127:0] expect_entry(input int k);
    if (last_unit) return {64'h0, $realtobits(1.0)};
    if (is_zero(diag[k])) return '0;
    return cdiv(1.0, 0.0, $bitstoreal(diag[k][63:0]), $bitstoreal(diag[k][127:64]));
  endfunction

  function automatic logic [63:0] rnd_part();
    real v;
    v = real'($urandom_range(1, 64)) / 8.0;
    if ($urandom_range(0, 1) == 1) v = -v;
    return $realtobits(v);
  endfunction

  function automatic void rand_diag();
    for (int k = 0; k < SIZE; k++)
      diag[k] = {($urandom_range(0, 3) == 0) ? $realtobits(0.0) : rnd_part(), rnd_part()};
  endfunction

  function automatic logic [SIZE*2*FLEN-1:0] make_row(input int r);
    logic [SIZE*2*FLEN-1:0] row;
    for (int k = 0; k < SIZE; k++)
      row[k*128 +: 128] = (k == r) ? diag[r] : {$urandom, $urandom, $urandom, $urandom};
    return row;
  endfunction

  function automatic void model_reset();
    m_mode = M_IDLE; m_iss = 0; m_ret = 0; m_fill = 0; m_done = 0; m_sing = 0;
    pq_data.delete(); pq_due.delete();
  endfunction

  // One clock: drive at negedge, compare 1 ns later, then advance the model by this cycle's handshakes.
  task automatic step(input bit st, input bit ud, input bit fl);
    bit exp_iv, fire_i, fire_r, run_div;
    int ra;
    logic [255:0] op;
    @(negedge clk_i);
    cyc++;
    start_i = st; unit_diag_i = ud; flush_i = fl;
    div_in_ready_i = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    run_div = (m_mode == M_DIV) && (m_iss < SIZE);
    if (!rnd_rows && run_div) begin
      ra = m_iss; row_rsp_valid_i = 1'b1;
    end else begin
      ra = ($urandom_range(0, 2) == 0 && m_iss < SIZE) ? m_iss : int'($urandom_range(0, SIZE - 1));
      row_rsp_valid_i = ($urandom_range(0, 3) != 0);
    end
    row_rsp_addr_i = AW'(ra);
    row_rsp_i = make_row(ra);
    if (pq_due.size() > 0 && pq_due[0] <= cyc) begin
      div_out_valid_i = 1'b1; div_result_i = pq_data[0];
    end else begin
      div_out_valid_i = 1'b0; div_result_i = {$urandom, $urandom, $urandom, $urandom};
    end
    #1;
    exp_iv = run_div && row_rsp_valid_i && (int'(row_rsp_addr_i) == m_iss) && ((m_iss - m_ret) < MO);
    chk("div_in_valid", div_in_valid_o, exp_iv);
    chk("row_req_valid", row_req_valid_o, run_div);
    if (run_div) chk("row_req_addr", row_req_addr_o, m_iss);
    chk("div_out_ready", div_out_ready_o, (m_mode == M_DIV) && !m_done);
    chk("busy", busy_o, (m_mode != M_IDLE) && !m_done);
    chk("done", done_o, m_done);
    chk("singular", singular_o, m_sing);
    chk("div_flush", div_flush_o, fl);
    fire_i = div_in_valid_o && div_in_ready_i;
    fire_r = div_out_valid_i && div_out_ready_o;
    if (fire_r) begin
      if (m_ret < SIZE && is_zero(diag[m_ret])) m_sing = 1;
      void'(pq_data.pop_front()); void'(pq_due.pop_front());
      m_ret++;
      if (m_ret == SIZE) m_done = 1;
    end
    if (fire_i) begin
      op = div_operands_o;
      if (m_iss < SIZE)
        chk("div_operands", op, {diag[m_iss][127:64], diag[m_iss][63:0], 64'h0, 64'h3FF0000000000000});
      if (is_zero(op[255:128])) pq_data.push_back({$urandom, $urandom, $urandom, $urandom});
      else pq_data.push_back(cdiv($bitstoreal(op[63:0]), $bitstoreal(op[127:64]),
                                  $bitstoreal(op[191:128]), $bitstoreal(op[255:192])));
      pq_due.push_back(cyc + lat);
      m_iss++;
    end
    if (m_mode == M_UNIT && !m_done) begin
      m_fill++;
      if (m_fill == SIZE) m_done = 1;
    end
    if (fl) model_reset();
    else if (st && (m_mode == M_IDLE || m_done)) begin
      model_reset();
      m_mode = ud ? M_UNIT : M_DIV;
      last_unit = ud;
      start_cyc = cyc;
    end
  endtask

  task automatic run(input bit ud, input int l, input bit rr, input bit rw, output int done_at);
    lat = l; rnd_ready = rr; rnd_rows = rw;
    step(1'b1, ud, 1'b0);
    done_at = -1;
    for (int b = 0; b < 2000 && done_at < 0; b++) begin
      step(1'b0, 1'b0, 1'b0);
      if (done_o) done_at = cyc - start_cyc;
    end
    chk("run_reaches_done", done_at >= 0, 1'b1);
  endtask

  task automatic rd(input int k, output logic [127:0] d);
    recip_rd_addr_i = AW'(k);
    step(1'b0, 1'b0, 1'b0);
    d = recip_rd_data_o;
  endtask

  task automatic readout();
    logic [127:0] d;
    for (int k = 0; k < SIZE; k++) begin
      rd(k, d);
      chk($sformatf("buf[%0d]", k), d, expect_entry(k));
    end
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0; start_i = 1'b0; flush_i = 1'b0;
    div_out_valid_i = 1'b0; row_rsp_valid_i = 1'b0; div_in_ready_i = 1'b0;
    #1;
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_singular", singular_o, 1'b0);
    chk("rst_row_req_valid", row_req_valid_o, 1'b0);
    chk("rst_row_req_addr", row_req_addr_o, 0);
    chk("rst_div_in_valid", div_in_valid_o, 1'b0);
    chk("rst_div_operands", div_operands_o, 0);
    chk("rst_div_out_ready", div_out_ready_o, 1'b0);
    model_reset();
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    int d;
    logic [127:0] v;
    model_reset();
    rnd_ready = 0; rnd_rows = 0; lat = 3; last_unit = 0;
    rand_diag();
    do_reset();

    rand_diag();
    diag[0] = {64'h0, $realtobits(2.0)};
    diag[1] = {64'h0, $realtobits(4.0)};
    diag[2] = {64'h0, $realtobits(0.5)};
    diag[3] = {64'h0, $realtobits(-1.0)};
    run(1'b0, 3, 1'b0, 1'b0, d);
    chk("done_cycle_L3", d, SIZE + 3 + 1);
    readout();
    rd(0, v); chk("lit_recip0", v[63:0], $realtobits(0.5));
    rd(1, v); chk("lit_recip1", v[63:0], $realtobits(0.25));
    rd(2, v); chk("lit_recip2", v[63:0], $realtobits(2.0));
    rd(3, v); chk("lit_recip3", v[63:0], $realtobits(-1.0));
    chk("lit_singular_clear", singular_o, 1'b0);

    rand_diag();
    run(1'b0, 12, 1'b0, 1'b0, d);
    readout();

    rand_diag();
    diag[2] = {64'h0, 64'h8000000000000000};
    run(1'b0, 5, 1'b0, 1'b0, d);
    readout();
    rd(2, v); chk("lit_zero_pivot_entry", v, 128'h0);
    chk("lit_singular_set", singular_o, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b0);

    run(1'b1, 0, 1'b0, 1'b0, d);
    chk("unit_done_cycle", d, SIZE + 1);
    readout();
    rd(SIZE - 1, v); chk("lit_unit_one", v, {64'h0, 64'h3FF0000000000000});

    repeat (3) begin
      rand_diag();
      run(1'b0, int'($urandom_range(1, 8)), 1'b1, 1'b1, d);
      readout();
    end

    rand_diag();
    diag[1] = '0;
    lat = 4; rnd_ready = 0; rnd_rows = 0;
    step(1'b1, 1'b0, 1'b0);
    for (int b = 0; b < 200 && m_iss < 7; b++) step(1'b0, 1'b0, 1'b0);
    chk("reach_issue_7", m_iss >= 7, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    chk("flush_not_busy", busy_o, 1'b0);
    rand_diag();
    for (int k = 0; k < SIZE; k++) if (is_zero(diag[k])) diag[k] = {64'h0, $realtobits(3.0)};
    run(1'b0, 4, 1'b0, 1'b0, d);
    readout();
    chk("lit_singular_after_flush", singular_o, 1'b0);

    rand_diag();
    lat = 6;
    step(1'b1, 1'b0, 1'b0);
    repeat (10) step(1'b0, 1'b0, 1'b0);
    do_reset();
    run(1'b0, 6, 1'b1, 1'b0, d);
    readout();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
